// File: rtl/ddr3_master_wr.sv
// ddr3_master_wr: packs JPEG bytes into 128-bit words and writes them to ping-pong DDR3 frame buffers
module ddr3_master_wr #(
  parameter logic [23:0] ADDR_BASE0  = 24'h000000,
  parameter logic [23:0] ADDR_BASE1  = 24'h400000,
  parameter logic [23:0] ADDR_STEP   = 24'd8,
  parameter logic [24:0] FRAME_MAX_B = 25'd4194304
) (
  input  logic         i_pclk84m,
  input  logic         i_rst_n,
  input  logic         i_jpeg_frame_start,
  input  logic         i_jpeg_byte_vld,
  input  logic [7:0]   i_jpeg_byte,
  input  logic         i_jpeg_frame_end,
  output logic         o_jpeg_wr_req,
  output logic [23:0]  o_jpeg_wr_addr,
  output logic [127:0] o_jpeg_wr_data,
  input  logic         i_jpeg_wr_down,
  output logic         o_frame_rdy,
  output logic [23:0]  o_frame_addr,
  output logic [24:0]  o_frame_byte_len,
  output logic         o_busy,
  output logic         o_error
);
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic buf_sel, pend;
  logic [127:0] pack_data, word_next;
  logic [3:0] pack_cnt;
  logic [24:0] byte_cnt;
  logic [23:0] wr_addr, base;
  logic [127:0] fifo_data [2];
  logic [23:0] fifo_addr [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] fifo_cnt;
  logic byte_in, byte_take, byte_ovf, word_full, pop, room, push, word_ovf, flush_push, abort, restart;
  assign base = buf_sel ? ADDR_BASE1 : ADDR_BASE0;
  assign byte_in = state == COLLECT && i_jpeg_byte_vld && !i_jpeg_frame_start;
  assign byte_take = byte_in && byte_cnt != FRAME_MAX_B;
  assign byte_ovf = byte_in && byte_cnt == FRAME_MAX_B;
  assign word_full = byte_take && &pack_cnt;
  assign pop = o_jpeg_wr_req && i_jpeg_wr_down;
  assign room = fifo_cnt != 2'd2 || pop;
  assign flush_push = state == FLUSH && !i_jpeg_frame_start && pack_cnt != 4'd0;
  assign push = (word_full || flush_push) && room;
  assign word_ovf = word_full && !room;
  assign abort = i_jpeg_frame_start && (state == COLLECT || state == FLUSH);
  assign restart = abort || (state == IDLE && state_n == COLLECT);
  assign o_jpeg_wr_req = fifo_cnt != 2'd0;
  assign o_jpeg_wr_addr = fifo_addr[rd_ptr];
  assign o_jpeg_wr_data = fifo_data[rd_ptr];
  // Bytes land big-endian at their final position, so a partial word is already zero-padded
  always_comb begin
    word_next = pack_data;
    if (byte_take) word_next[{~pack_cnt, 3'b000} +: 8] = i_jpeg_byte;
  end
  always_ff @(posedge i_pclk84m) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (i_jpeg_frame_start || pend) ? COLLECT : IDLE;
      COLLECT: state_n = i_jpeg_frame_start ? COLLECT : i_jpeg_frame_end ? FLUSH : COLLECT;
      FLUSH:   state_n = i_jpeg_frame_start ? COLLECT : (pack_cnt == 4'd0 && fifo_cnt == 2'd0) ? DONE : FLUSH;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state != IDLE;
    o_frame_rdy = state == DONE;
  end
  always_ff @(posedge i_pclk84m) begin
    if (!i_rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_addr[0] <= '0;
      fifo_addr[1] <= '0;
      fifo_cnt <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      pack_data <= '0;
      pack_cnt <= '0;
      byte_cnt <= '0;
      wr_addr <= '0;
      buf_sel <= 1'b0;
      pend <= 1'b0;
      o_error <= 1'b0;
      o_frame_addr <= '0;
      o_frame_byte_len <= '0;
    end else begin
      if (restart) begin
        fifo_cnt <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        pack_data <= '0;
        pack_cnt <= '0;
        byte_cnt <= '0;
        wr_addr <= base;
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= word_next;
          fifo_addr[wr_ptr] <= wr_addr;
          wr_ptr <= ~wr_ptr;
          wr_addr <= wr_addr + ADDR_STEP;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        if (byte_take) byte_cnt <= byte_cnt + 25'd1;
        pack_cnt <= push ? 4'd0 : pack_cnt + 4'(byte_take);
        pack_data <= (word_full || push) ? '0 : word_next;
      end
      o_error <= o_error | word_ovf | byte_ovf;
      if (state == FLUSH && state_n == DONE) begin
        o_frame_addr <= base;
        o_frame_byte_len <= byte_cnt;
      end
      buf_sel <= buf_sel ^ (state == DONE);
      pend <= state == DONE ? i_jpeg_frame_start : state == IDLE ? 1'b0 : pend;
    end
  end
endmodule
